// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write-port signals shared by the write arbiter.
// The arbiter uses the slave modport; the requesters/FIFO environment uses master.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4
) ();
  localparam int unsigned IdW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       gnt;
  logic [IdW-1:0]        gnt_id;
  logic                  busy;

  modport slave (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, gnt, gnt_id, busy
  );

  modport master (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, gnt, gnt_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing an async FIFO write port among NREQ requesters,
// granting bounded bursts of up to BURST_LEN words with wfull backpressure.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic           wclk,
  input  logic           wrst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d;
  logic [IdW-1:0]  rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            busy;
  logic            valid_g;
  logic            winc;
  logic            found;
  logic [IdW-1:0]  pick;
  logic [IdW-1:0]  next_rr;
  int unsigned     idx;

  assign busy    = (state_q == StBurst);
  // gnt_q is one-hot on the granted requester while busy, so it doubles as a select mask.
  assign valid_g = |(bus.req_valid & gnt_q);
  assign winc    = busy && !bus.wfull && valid_g;
  assign next_rr = (gnt_id_q == IdW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;

  // First valid requester at or above the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_q) + k) % NREQ;
      if (!found && bus.req_valid[IdW'(idx)]) begin
        found = 1'b1;
        pick  = IdW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StBurst;
          gnt_id_d = pick;
          gnt_d    = {{(NREQ - 1){1'b0}}, 1'b1} << pick;
          cnt_d    = '0;
        end
      end
      StBurst: begin
        if (winc) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!valid_g || (winc && (cnt_q == CntW'(BURST_LEN - 1)))) begin
          state_d  = StIdle;
          gnt_d    = '0;
          gnt_id_d = '0;
          cnt_d    = '0;
          rr_d     = next_rr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    bus.wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (busy && (gnt_id_q == IdW'(i))) begin
        bus.wdata = bus.req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign bus.req_ready = gnt_q & {NREQ{busy && !bus.wfull}};
  assign bus.winc      = winc;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.busy      = busy;

  a_no_winc_full: assert property (@(posedge wclk) disable iff (wrst) !(bus.winc && bus.wfull));
  a_gnt_onehot0:  assert property (@(posedge wclk) disable iff (wrst) $onehot0(bus.gnt));
  a_rdy_onehot0:  assert property (@(posedge wclk) disable iff (wrst) $onehot0(bus.req_ready));
  a_winc_busy:    assert property (@(posedge wclk) disable iff (wrst) bus.winc |-> bus.busy);
endmodule
